// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDRESS_SIZE_DEF = 32;
    localparam int LINE_WORDS_DEF   = 4;
    localparam int NUM_LINES_DEF    = 4;

    localparam int BYTE_BITS   = 2;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS_DEF);
    localparam int INDEX_BITS  = $clog2(NUM_LINES_DEF);
    localparam int TAG_BITS    = ADDRESS_SIZE_DEF - INDEX_BITS - OFFSET_BITS - BYTE_BITS;
    localparam int LINE_BITS   = ADDRESS_SIZE_DEF * LINE_WORDS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: one synchronous write port, one combinational read port.
// Only the valid bits are reset; tags and data are don't-care until validated.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int IDX_W     = INDEX_BITS,
    parameter int TAG_W     = TAG_BITS,
    parameter int LINE_W    = LINE_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_W-1:0]    lines [NUM_LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = lines[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, single-line refill over req/ack.
// ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int LINE_WORDS   = LINE_WORDS_DEF,
    parameter int NUM_LINES    = NUM_LINES_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDRESS_SIZE-1:0]          pc,
    input  logic                             fetch_valid,
    input  logic                             I_stall_in,
    output logic [ADDRESS_SIZE-1:0]          I_instruction,
    output logic                             I_stall,
    output logic                             mem_req,
    output logic [ADDRESS_SIZE-1:0]          mem_addr,
    input  logic                             mem_ack,
    input  logic [ADDRESS_SIZE*LINE_WORDS-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                      hit_count,
    output logic [31:0]                      miss_count
`endif
);

    localparam int BYTE_W = 2;
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDRESS_SIZE - IDX_W - OFF_W - BYTE_W;
    localparam int LINE_W = ADDRESS_SIZE * LINE_WORDS;

    state_t state, next_state;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_index;
    logic [TAG_W-1:0]  pc_tag;
    logic              unused_pc_bits;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;
    logic [ADDRESS_SIZE-1:0] hit_word;
    logic              hit;

    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_index;
    logic              start_fill;
    logic              wr_en;

    assign pc_off         = pc[BYTE_W +: OFF_W];
    assign pc_index       = pc[BYTE_W + OFF_W +: IDX_W];
    assign pc_tag         = pc[ADDRESS_SIZE-1 -: TAG_W];
    assign unused_pc_bits = &{1'b0, pc[BYTE_W-1:0]};

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .LINE_W    (LINE_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (fill_index),
        .wr_tag   (fill_tag),
        .wr_data  (mem_rdata)
    );

    assign hit      = fetch_valid && rd_valid && (rd_tag == pc_tag);
    assign hit_word = rd_data[pc_off*ADDRESS_SIZE +: ADDRESS_SIZE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fill address is captured at miss detection so pc may wander during the fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_tag   <= '0;
            fill_index <= '0;
        end else if (start_fill) begin
            fill_tag   <= pc_tag;
            fill_index <= pc_index;
        end
    end

    assign mem_addr = {fill_tag, fill_index, {(OFF_W + BYTE_W){1'b0}}};

    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        I_stall       = 1'b0;
        I_instruction = '0;
        start_fill    = 1'b0;
        wr_en         = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_valid) begin
                    if (hit) begin
                        I_instruction = hit_word;
                    end else begin
                        I_stall = 1'b1;
                        if (!I_stall_in) begin
                            start_fill = 1'b1;
                            next_state = REQ;
                        end
                    end
                end
            end
            REQ: begin
                mem_req = 1'b1;
                I_stall = 1'b1;
                if (mem_ack) begin
                    wr_en      = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                I_stall    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && hit && !I_stall_in) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache against a behavioural cache model.
module tb_icache;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc;
    logic         fetch_valid;
    logic         I_stall_in;
    logic [31:0]  I_instruction;
    logic         I_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    icache dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .I_stall_in    (I_stall_in),
        .I_instruction (I_instruction),
        .I_stall       (I_stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the cache contents plus where the refill stands.
    bit           m_valid [4];
    logic [31:0]  m_tag   [4];
    logic [31:0]  m_data  [4][4];
    int           m_phase;       // 0 looking up, 1 waiting for memory, 2 refill cycle
    logic [31:0]  m_fill;
    int           m_req_cycles;
    int unsigned  m_hits;
    int unsigned  m_misses;

    int   ack_delay = 1;
    bit   spurious  = 0;
    logic last_stall;
    logic last_req;
    logic [31:0] last_instr;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int w);
        if (line == 32'h1000) return 32'h11 * (w + 1);
        return (line + 32'(4 * w)) ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        m_phase      = 0;
        m_fill       = 32'h0;
        m_req_cycles = 0;
        m_hits       = 0;
        m_misses     = 0;
    endtask

    // Called just after a rising edge; drives one cycle, checks, advances the model.
    task automatic step(input logic [31:0] p, input bit fv, input bit sin);
        int   idx, off, fidx;
        logic [31:0] tg, exp_i;
        bit   hit, ack, exp_s, exp_r;
        pc          = p;
        fetch_valid = fv;
        I_stall_in  = sin;
        mem_rdata   = {$urandom, $urandom, $urandom, $urandom};
        ack = 0;
        if (m_phase == 1 && m_req_cycles >= ack_delay) ack = 1;
        else if (spurious && m_phase != 1 && $urandom_range(0, 3) == 0) ack = 1;
        if (ack && m_phase == 1)
            for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = mem_word(m_fill, w);
        mem_ack = ack;
        #2;
        idx = int'((p / 16) % 4);
        off = int'((p / 4) % 4);
        tg  = p / 64;
        hit = fv && m_valid[idx] && (m_tag[idx] == tg);
        exp_i = 32'h0;
        exp_s = 0;
        exp_r = 0;
        if (m_phase == 0) begin
            if (hit) exp_i = m_data[idx][off];
            exp_s = fv && !hit;
        end else begin
            exp_s = 1;
            exp_r = (m_phase == 1);
        end
        chk("I_stall", 32'(I_stall), 32'(exp_s));
        chk("I_instruction", I_instruction, exp_i);
        chk("mem_req", 32'(mem_req), 32'(exp_r));
        chk("mem_addr", mem_addr, m_fill);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
        last_stall = I_stall;
        last_req   = mem_req;
        last_instr = I_instruction;
        last_addr  = mem_addr;
        @(posedge clk);
        case (m_phase)
            0: begin
                if (hit && !sin) m_hits++;
                if (fv && !hit && !sin) begin
                    m_fill       = p & ~32'hF;
                    m_phase      = 1;
                    m_req_cycles = 0;
                    m_misses++;
                end
            end
            1: begin
                if (ack) begin
                    fidx = int'((m_fill / 16) % 4);
                    for (int w = 0; w < 4; w++) m_data[fidx][w] = mem_rdata[w*32 +: 32];
                    m_valid[fidx] = 1;
                    m_tag[fidx]   = m_fill / 64;
                    m_phase       = 2;
                end else begin
                    m_req_cycles++;
                end
            end
            default: m_phase = 0;
        endcase
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle with an ack pending across the edge.
    task automatic reset_midcycle();
        mem_ack = 1'b1;
        reset   = 1'b1;
        #1;
        model_reset();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Repeats a pc until the cache delivers it; returns the number of stalled cycles.
    task automatic run_until_hit(input logic [31:0] p, output int stalls);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(p, 1, 0);
            if (!last_stall) return;
            stalls++;
        end
        chk("hit_timeout", 32'(stalls), 32'd0);
    endtask

    initial begin
        int stalls;
        bit saw_1000, saw_2000;
        logic [31:0] p;

        reset = 1'b1; pc = 32'h0; fetch_valid = 1'b0; I_stall_in = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        #1;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_stall", 32'(I_stall), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Cold miss: ack one cycle after req rises.
        ack_delay = 1;
        run_until_hit(32'h1000, stalls);
        chk("cold_stall_cycles", 32'(stalls), 32'd4);
        chk("cold_word0", last_instr, 32'h11);
        step(32'h1004, 1, 0); chk("cold_word1", last_instr, 32'h22);
        step(32'h1008, 1, 0); chk("cold_word2", last_instr, 32'h33);
        step(32'h100C, 1, 0); chk("cold_word3", last_instr, 32'h44);
        chk("cold_word3_stall", 32'(last_stall), 32'd0);
`ifdef ICACHE_STATS_EN
        chk("stats_hits", hit_count, 32'd4);
        chk("stats_misses", miss_count, 32'd1);
`endif

        // Conflict eviction at the same index.
        step(32'h1040, 1, 0);
        chk("evict_miss", 32'(last_stall), 32'd1);
        step(32'h1040, 1, 0);
        chk("evict_addr", last_addr, 32'h1040);
        run_until_hit(32'h1040, stalls);
        chk("evict_word", last_instr, mem_word(32'h1040, 0));

        // Return to 0x1000 misses; pc moves to 0x2000 during the fill.
        ack_delay = 2;
        step(32'h1000, 1, 0);
        chk("remiss_1000", 32'(last_stall), 32'd1);
        saw_1000 = 0; saw_2000 = 0;
        for (int i = 0; i < 20 && last_stall; i++) begin
            step(32'h2000, 1, 0);
            if (last_req && last_addr == 32'h1000) saw_1000 = 1;
            if (last_req && last_addr == 32'h2000) saw_2000 = 1;
        end
        chk("pcmove_req_1000", 32'(saw_1000), 32'd1);
        chk("pcmove_req_2000", 32'(saw_2000), 32'd1);
        chk("pcmove_word", last_instr, mem_word(32'h2000, 0));

        // Reset during REQ drops the fill; 0x1000 then misses.
        ack_delay = 5;
        step(32'h3000, 1, 0);
        step(32'h3000, 1, 0);
        chk("midfill_req", 32'(last_req), 32'd1);
        reset_midcycle();
        ack_delay = 1;
        step(32'h1000, 1, 0);
        chk("post_reset_miss", 32'(last_stall), 32'd1);
        run_until_hit(32'h1000, stalls);

        // Downstream stall holds off a miss.
        for (int i = 0; i < 3; i++) begin
            step(32'h5000, 1, 1);
            chk("stall_in_no_req", 32'(last_req), 32'd0);
        end
        step(32'h5000, 1, 0);
        step(32'h5000, 1, 0);
        chk("stall_in_release_req", 32'(last_req), 32'd1);
        run_until_hit(32'h5000, stalls);

        // Random traffic over a small working set with spurious acks.
        spurious = 1;
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 0) ack_delay = $urandom_range(0, 3);
            p = 32'h8000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) reset_midcycle();
            else step(p, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
